// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator: 640x480@60 defaults,
// coordinate type, sync/active flag bundle and the colour bit-replication helper.
package vga_pkg;

   localparam int unsigned COORD_W   = 10;
   localparam int unsigned FRAME_W   = 16;
   localparam int unsigned MAX_TOTAL = 1024;
   localparam int unsigned MAX_LAT   = 7;

   // Widest channel the expand helper handles
   localparam int unsigned EXP_W     = 16;
   localparam int unsigned EXP_IDX_W = $clog2(EXP_W);

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      logic act;
      logic hs;
      logic vs;
   } flags_t;

   // MSB-first replication of an in_w-bit value to out_w bits, truncated
   function automatic logic [EXP_W-1:0] expand(input logic [EXP_W-1:0] val,
                                                input int unsigned      in_w,
                                                input int unsigned      out_w);
      logic [EXP_W-1:0] res;
      res = '0;
      for (int unsigned i = 0; i < EXP_W; i++) begin
         if ((i < out_w) && (in_w != 0))
            res[EXP_IDX_W'(out_w - 1 - i)] = val[EXP_IDX_W'(in_w - 1 - (i % in_w))];
      end
      return res;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ce-qualified shift register that lines up the request-side flags with a
// pipelined colour source; collapses to a wire when DEPTH is zero.
module vga_delay_line #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 2
) (
   input  logic             vgaclk,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{vgaclk, rst, ce};
      assign q = d;
   end else begin : g_shift
      localparam int unsigned SR_W = WIDTH * DEPTH;

      // Newest entry sits in the low bits, the oldest leaves from the top
      logic [SR_W-1:0] sr;

      always_ff @(posedge vgaclk) begin
         if (rst)
            sr <= '0;
         else if (ce)
            sr <= (sr << WIDTH) | SR_W'(d);
      end

      assign q = sr[SR_W-1 -: WIDTH];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: raster counters, request-side strobes,
// latency-matched sync/blank and registered, bit-replicated colour outputs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0,
   parameter int unsigned IN_R_W   = 3,
   parameter int unsigned IN_G_W   = 3,
   parameter int unsigned IN_B_W   = 2,
   parameter int unsigned OUT_W    = 4,
   parameter int unsigned LAT      = 2
) (
   input  logic               vgaclk,
   input  logic               rst,
   input  logic               ce,
   input  logic [IN_R_W-1:0]  in_red,
   input  logic [IN_G_W-1:0]  in_green,
   input  logic [IN_B_W-1:0]  in_blue,
   output logic [COORD_W-1:0] hc_out,
   output logic [COORD_W-1:0] vc_out,
   output logic               req_active,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [OUT_W-1:0]   red,
   output logic [OUT_W-1:0]   green,
   output logic [OUT_W-1:0]   blue
);

   localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam coord_t      H_LAST       = COORD_W'(H_TOTAL - 1);
   localparam coord_t      V_LAST       = COORD_W'(V_TOTAL - 1);

   if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
   end
   if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
   end
   if (LAT > MAX_LAT) begin : g_bad_lat
      $error("vga_timing_gen: LAT %0d exceeds %0d", LAT, MAX_LAT);
   end
   if ((IN_R_W > OUT_W) || (IN_G_W > OUT_W) || (IN_B_W > OUT_W)) begin : g_bad_in_w
      $error("vga_timing_gen: an input colour width exceeds OUT_W %0d", OUT_W);
   end
   if (OUT_W > EXP_W) begin : g_bad_out_w
      $error("vga_timing_gen: OUT_W %0d exceeds %0d", OUT_W, EXP_W);
   end

   coord_t hc;
   coord_t vc;
   flags_t req_flags;
   flags_t dly_flags;
   logic [OUT_W-1:0] red_x;
   logic [OUT_W-1:0] green_x;
   logic [OUT_W-1:0] blue_x;

   // Raster counters and completed-frame count
   always_ff @(posedge vgaclk) begin
      if (rst) begin
         hc        <= '0;
         vc        <= '0;
         frame_cnt <= '0;
      end else if (ce) begin
         if (hc == H_LAST) begin
            hc <= '0;
            if (vc == V_LAST) begin
               vc        <= '0;
               frame_cnt <= frame_cnt + FRAME_W'(1);
            end else begin
               vc <= vc + COORD_W'(1);
            end
         end else begin
            hc <= hc + COORD_W'(1);
         end
      end
   end

   // Request-side decode of the coordinate currently presented
   always_comb begin
      req_flags     = '0;
      req_flags.act = (32'(hc) < H_ACTIVE) && (32'(vc) < V_ACTIVE);
      req_flags.hs  = (32'(hc) >= H_SYNC_START) && (32'(hc) < H_SYNC_END);
      req_flags.vs  = (32'(vc) >= V_SYNC_START) && (32'(vc) < V_SYNC_END);
   end

   assign hc_out      = hc;
   assign vc_out      = vc;
   assign req_active  = req_flags.act;
   assign line_start  = ce && (hc == '0);
   assign frame_start = ce && (hc == '0) && (vc == '0);

   vga_delay_line #(
      .WIDTH ($bits(flags_t)),
      .DEPTH (LAT)
   ) u_flag_dly (
      .vgaclk (vgaclk),
      .rst    (rst),
      .ce     (ce),
      .d      (req_flags),
      .q      (dly_flags)
   );

   assign red_x   = OUT_W'(expand(EXP_W'(in_red),   IN_R_W, OUT_W));
   assign green_x = OUT_W'(expand(EXP_W'(in_green), IN_G_W, OUT_W));
   assign blue_x  = OUT_W'(expand(EXP_W'(in_blue),  IN_B_W, OUT_W));

   // Output register; blanked colour is forced to zero
   always_ff @(posedge vgaclk) begin
      if (rst) begin
         de    <= 1'b0;
         hsync <= ~H_POL;
         vsync <= ~V_POL;
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else if (ce) begin
         de    <= dly_flags.act;
         hsync <= dly_flags.hs ? H_POL : ~H_POL;
         vsync <= dly_flags.vs ? V_POL : ~V_POL;
         red   <= dly_flags.act ? red_x   : '0;
         green <= dly_flags.act ? green_x : '0;
         blue  <= dly_flags.act ? blue_x  : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, small with positive sync and
// LAT=3, small with LAT=0 and odd widths) checked every cycle against a raster model.
module tb_vga_timing_gen;

   typedef struct {
      int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
      int hpol, vpol, lat, rw, gw, bw, ow;
   } cfg_t;

   localparam int B_HA = 8, B_HFP = 2, B_HSW = 3, B_HBP = 2;
   localparam int B_VA = 5, B_VFP = 1, B_VSW = 2, B_VBP = 1;
   localparam int C_HA = 6, C_HFP = 1, C_HSW = 2, C_HBP = 1;
   localparam int C_VA = 4, C_VFP = 1, C_VSW = 1, C_VBP = 1;

   logic vgaclk = 1'b0;
   logic rst, ce;

   logic [2:0] in_red_a, in_green_a, in_red_b, in_green_b;
   logic [1:0] in_blue_a, in_blue_b, in_red_c;
   logic [0:0] in_green_c;
   logic [2:0] in_blue_c;

   logic [9:0]  hc_a, vc_a, hc_b, vc_b, hc_c, vc_c;
   logic        ra_a, ls_a, fs_a, hs_a, vs_a, de_a;
   logic        ra_b, ls_b, fs_b, hs_b, vs_b, de_b;
   logic        ra_c, ls_c, fs_c, hs_c, vs_c, de_c;
   logic [15:0] fc_a, fc_b, fc_c;
   logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
   logic [4:0]  red_c, green_c, blue_c;

   int   checks = 0;
   int   failures = 0;
   int   e = 0;
   int   mode = 0;
   cfg_t cfg[3];
   int   drv[3][3];
   int   cap[3][3];

   always #20 vgaclk = ~vgaclk;

   vga_timing_gen u_a (
      .vgaclk(vgaclk), .rst(rst), .ce(ce),
      .in_red(in_red_a), .in_green(in_green_a), .in_blue(in_blue_a),
      .hc_out(hc_a), .vc_out(vc_a), .req_active(ra_a), .line_start(ls_a),
      .frame_start(fs_a), .frame_cnt(fc_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
      .red(red_a), .green(green_a), .blue(blue_a));

   vga_timing_gen #(
      .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HSW), .H_BP(B_HBP),
      .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VSW), .V_BP(B_VBP),
      .H_POL(1'b1), .V_POL(1'b1), .LAT(3)
   ) u_b (
      .vgaclk(vgaclk), .rst(rst), .ce(ce),
      .in_red(in_red_b), .in_green(in_green_b), .in_blue(in_blue_b),
      .hc_out(hc_b), .vc_out(vc_b), .req_active(ra_b), .line_start(ls_b),
      .frame_start(fs_b), .frame_cnt(fc_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
      .red(red_b), .green(green_b), .blue(blue_b));

   vga_timing_gen #(
      .H_ACTIVE(C_HA), .H_FP(C_HFP), .H_SYNC(C_HSW), .H_BP(C_HBP),
      .V_ACTIVE(C_VA), .V_FP(C_VFP), .V_SYNC(C_VSW), .V_BP(C_VBP),
      .IN_R_W(2), .IN_G_W(1), .IN_B_W(3), .OUT_W(5), .LAT(0)
   ) u_c (
      .vgaclk(vgaclk), .rst(rst), .ce(ce),
      .in_red(in_red_c), .in_green(in_green_c), .in_blue(in_blue_c),
      .hc_out(hc_c), .vc_out(vc_c), .req_active(ra_c), .line_start(ls_c),
      .frame_start(fs_c), .frame_cnt(fc_c), .hsync(hs_c), .vsync(vs_c), .de(de_c),
      .red(red_c), .green(green_c), .blue(blue_c));

   function automatic int htot(input cfg_t c);
      return c.ha + c.hfp + c.hsw + c.hbp;
   endfunction

   function automatic int vtot(input cfg_t c);
      return c.va + c.vfp + c.vsw + c.vbp;
   endfunction

   // Flags of raster position idx (0 act, 1 hs, 2 vs); before the first pixel all are 0
   function automatic int flag(input cfg_t c, input int idx, input int which);
      int h, v;
      if (idx < 0) return 0;
      h = idx % htot(c);
      v = (idx / htot(c)) % vtot(c);
      case (which)
         0:       return int'(h < c.ha && v < c.va);
         1:       return int'(h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw);
         default: return int'(v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw);
      endcase
   endfunction

   function automatic int xp(input int v, input int iw, input int ow);
      int res = 0;
      for (int k = 0; k < ow; k++) res = (res << 1) | ((v >> (iw - 1 - (k % iw))) & 1);
      return res;
   endfunction

   // Colour a source would produce for raster position idx
   function automatic int src(input int ch, input cfg_t c, input int idx, input int md);
      int h, v, val, w;
      if (idx < 0) return 0;
      h = idx % htot(c);
      v = (idx / htot(c)) % vtot(c);
      w = (ch == 0) ? c.rw : (ch == 1) ? c.gw : c.bw;
      if (md == 0) val = (ch == 0) ? 5 : (ch == 1) ? 3 : 2;
      else         val = (ch == 0) ? h : (ch == 1) ? v : (h >> 3);
      return val & ((1 << w) - 1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (e=%0d)", nm, got, exp, e);
      end
   endtask

   task automatic check_dut(input int d, input string nm,
                            input logic [31:0] hc, vc, ra, ls, fs, fc,
                            input logic [31:0] hs, vs, dd, r, g, b);
      cfg_t c;
      int ht, vt, ehc, evc, old, act;
      c   = cfg[d];
      ht  = htot(c);
      vt  = vtot(c);
      ehc = e % ht;
      evc = (e / ht) % vt;
      old = e - 1 - c.lat;
      act = flag(c, old, 0);
      chk({nm, ".hc"}, hc, ehc);
      chk({nm, ".vc"}, vc, evc);
      chk({nm, ".req_active"}, ra, flag(c, e, 0));
      chk({nm, ".line_start"}, ls, int'(ce && ehc == 0));
      chk({nm, ".frame_start"}, fs, int'(ce && ehc == 0 && evc == 0));
      chk({nm, ".frame_cnt"}, fc, (e / (ht * vt)) % 65536);
      chk({nm, ".hsync"}, hs, flag(c, old, 1) != 0 ? c.hpol : 1 - c.hpol);
      chk({nm, ".vsync"}, vs, flag(c, old, 2) != 0 ? c.vpol : 1 - c.vpol);
      chk({nm, ".de"}, dd, act);
      chk({nm, ".red"},   r, act != 0 ? xp(cap[d][0], c.rw, c.ow) : 0);
      chk({nm, ".green"}, g, act != 0 ? xp(cap[d][1], c.gw, c.ow) : 0);
      chk({nm, ".blue"},  b, act != 0 ? xp(cap[d][2], c.bw, c.ow) : 0);
   endtask

   task automatic check_all();
      check_dut(0, "A", 32'(hc_a), 32'(vc_a), 32'(ra_a), 32'(ls_a), 32'(fs_a), 32'(fc_a),
                32'(hs_a), 32'(vs_a), 32'(de_a), 32'(red_a), 32'(green_a), 32'(blue_a));
      check_dut(1, "B", 32'(hc_b), 32'(vc_b), 32'(ra_b), 32'(ls_b), 32'(fs_b), 32'(fc_b),
                32'(hs_b), 32'(vs_b), 32'(de_b), 32'(red_b), 32'(green_b), 32'(blue_b));
      check_dut(2, "C", 32'(hc_c), 32'(vc_c), 32'(ra_c), 32'(ls_c), 32'(fs_c), 32'(fc_c),
                32'(hs_c), 32'(vs_c), 32'(de_c), 32'(red_c), 32'(green_c), 32'(blue_c));
   endtask

   // Present the colour owed for the coordinate shown LAT enabled cycles ago
   task automatic drive_src();
      for (int d = 0; d < 3; d++)
         for (int ch = 0; ch < 3; ch++)
            drv[d][ch] = src(ch, cfg[d], e - cfg[d].lat, mode);
      in_red_a = 3'(drv[0][0]); in_green_a = 3'(drv[0][1]); in_blue_a = 2'(drv[0][2]);
      in_red_b = 3'(drv[1][0]); in_green_b = 3'(drv[1][1]); in_blue_b = 2'(drv[1][2]);
      in_red_c = 2'(drv[2][0]); in_green_c = 1'(drv[2][1]); in_blue_c = 3'(drv[2][2]);
   endtask

   task automatic step();
      @(posedge vgaclk);
      if (rst) e = 0;
      else if (ce) begin
         e++;
         cap = drv;
      end
      #1;
      check_all();
   endtask

   initial begin
      cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 3, 3, 2, 4};
      cfg[1] = '{B_HA, B_HFP, B_HSW, B_HBP, B_VA, B_VFP, B_VSW, B_VBP, 1, 1, 3, 3, 3, 2, 4};
      cfg[2] = '{C_HA, C_HFP, C_HSW, C_HBP, C_VA, C_VFP, C_VSW, C_VBP, 0, 0, 0, 2, 1, 3, 5};

      rst = 1'b1;
      ce  = 1'b1;
      repeat (3) begin
         drive_src();
         step();
      end
      chk("reset.hsync_a_idle", 32'(hs_a), 1);
      chk("reset.vsync_a_idle", 32'(vs_a), 1);
      chk("reset.hsync_b_idle", 32'(hs_b), 0);
      chk("reset.vsync_b_idle", 32'(vs_b), 0);
      chk("reset.de_a", 32'(de_a), 0);
      chk("reset.frame_start_a", 32'(fs_a), 1);

      // Constant colour, continuous ce
      rst = 1'b0;
      for (int n = 1; n <= 1500; n++) begin
         drive_src();
         step();
         if (n == 1) begin
            chk("const.red_c", 32'(red_c), 32'h0A);
            chk("const.green_c", 32'(green_c), 32'h1F);
            chk("const.blue_c", 32'(blue_c), 32'h09);
         end
         if (n == 2) chk("lat.de_a_before", 32'(de_a), 0);
         if (n == 3) begin
            chk("lat.de_a_first", 32'(de_a), 1);
            chk("const.red_a", 32'(red_a), 32'hB);
            chk("const.green_a", 32'(green_a), 32'h6);
            chk("const.blue_a", 32'(blue_a), 32'hA);
         end
         if (n == 643) begin
            chk("blank.de_a", 32'(de_a), 0);
            chk("blank.red_a", 32'(red_a), 0);
         end
         if (n == 658) chk("hsync_a.before", 32'(hs_a), 1);
         if (n == 659) chk("hsync_a.first", 32'(hs_a), 0);
         if (n == 754) chk("hsync_a.last", 32'(hs_a), 0);
         if (n == 755) chk("hsync_a.after", 32'(hs_a), 1);
         if (n == 803) chk("line2.de_a", 32'(de_a), 1);
         if (n == 1459) chk("line2.hsync_a", 32'(hs_a), 0);
         if (n == 134) begin
            chk("wrap.hc_b", 32'(hc_b), 14);
            chk("wrap.vc_b", 32'(vc_b), 8);
            chk("wrap.frame_cnt_b0", 32'(fc_b), 0);
         end
         if (n == 135) begin
            chk("wrap.frame_cnt_b1", 32'(fc_b), 1);
            chk("wrap.frame_start_b", 32'(fs_b), 1);
         end
         if (n == 270) chk("wrap.frame_cnt_b2", 32'(fc_b), 2);
      end

      // Coordinate-dependent colour
      rst  = 1'b1;
      mode = 1;
      repeat (2) begin
         drive_src();
         step();
      end
      rst = 1'b0;
      for (int n = 1; n <= 1700; n++) begin
         drive_src();
         step();
         if (n == 3) chk("pat.red_a_hc0", 32'(red_a), 0);
         if (n == 4) chk("pat.red_a_hc1", 32'(red_a), 32'h2);
         if (n == 642) chk("pat.red_a_hc639", 32'(red_a), 32'hF);
         if (n == 643) chk("pat.red_a_hc640", 32'(red_a), 0);
         if (n == 803) begin
            chk("pat.red_a_line1", 32'(red_a), 0);
            chk("pat.green_a_line1", 32'(green_a), 32'h2);
         end
      end

      // ce toggling every clock
      rst = 1'b1;
      repeat (2) begin
         drive_src();
         step();
      end
      rst = 1'b0;
      for (int n = 1; n <= 600; n++) begin
         ce = (n % 2 == 1);
         drive_src();
         step();
         if (n == 26) chk("gap.hsync_b_before", 32'(hs_b), 0);
         if (n == 27) chk("gap.hsync_b_first", 32'(hs_b), 1);
         if (n == 32) chk("gap.hsync_b_last", 32'(hs_b), 1);
         if (n == 33) chk("gap.hsync_b_after", 32'(hs_b), 0);
         if (n == 268) chk("gap.frame_cnt_b0", 32'(fc_b), 0);
         if (n == 270) chk("gap.frame_cnt_b1", 32'(fc_b), 1);
      end

      // Reset in the middle of vsync, with ce low on the reset edge
      ce  = 1'b1;
      rst = 1'b1;
      drive_src();
      step();
      rst = 1'b0;
      for (int n = 1; n <= 245; n++) begin
         drive_src();
         step();
      end
      chk("midrst.pre_vsync_b", 32'(vs_b), 1);
      chk("midrst.pre_hc_b", 32'(hc_b), 5);
      chk("midrst.pre_vc_b", 32'(vc_b), 7);
      chk("midrst.pre_frame_cnt_b", 32'(fc_b), 1);
      rst = 1'b1;
      ce  = 1'b0;
      drive_src();
      step();
      chk("midrst.hc_b", 32'(hc_b), 0);
      chk("midrst.vc_b", 32'(vc_b), 0);
      chk("midrst.vsync_b", 32'(vs_b), 0);
      chk("midrst.de_b", 32'(de_b), 0);
      chk("midrst.red_b", 32'(red_b), 0);
      chk("midrst.frame_cnt_b", 32'(fc_b), 0);
      rst = 1'b0;
      ce  = 1'b1;
      for (int n = 1; n <= 200; n++) begin
         drive_src();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
